// File: rtl/mmio_bus.sv
// Memory-mapped CPU bus: data memory, interval timer, LED register and cycle counter.
// Loads are registered with a one-cycle rvalid strobe; unmapped accesses raise bus_err.
module mmio_bus #(
  parameter int unsigned DMEM_AW = 9,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned LED_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             write_enable,
  input  logic [31:0]      Address,
  input  logic [31:0]      din,
  output logic [31:0]      dout,
  output logic             rvalid,
  output logic             bus_err,
  output logic             irq,
  output logic [LED_W-1:0] leds,
  output logic [31:0]      cycles_dout
);

  localparam int unsigned DMEM_DEPTH = 2 ** DMEM_AW;
  localparam logic [29:0] A_CYCLES = 30'h1000_0000;
  localparam logic [29:0] A_TCTRL  = 30'h1000_0001;
  localparam logic [29:0] A_TCMP   = 30'h1000_0002;
  localparam logic [29:0] A_TSTAT  = 30'h1000_0003;
  localparam logic [29:0] A_TCNT   = 30'h1000_0004;
  localparam logic [29:0] A_LED    = 30'h1000_0005;

  logic [31:0]        mem [DMEM_DEPTH];
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   tcmp_q, tcmp_d;
  logic [CNT_W-1:0]   tcnt_q, tcnt_d;
  logic [1:0]         tctrl_q, tctrl_d;
  logic               flag_q, flag_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [31:0]        dout_q, dout_d;
  logic               rvalid_q, rvalid_d;
  logic               bus_err_q, bus_err_d;
  logic               irq_q, irq_d;

  logic [29:0]        waddr;
  logic [DMEM_AW-1:0] mem_idx;
  logic [31:0]        mem_rdata;
  logic               sel_mem, sel_cyc, sel_tctrl, sel_tcmp, sel_tstat, sel_tcnt, sel_led;
  logic               mapped, wr, rd, match;
  logic               unused_bits;

  // Address decode; byte-offset bits are ignored and DMEM upper bits alias.
  assign waddr     = Address[31:2];
  assign mem_idx   = Address[DMEM_AW+1:2];
  assign sel_mem   = (Address[31:30] == 2'b00);
  assign sel_cyc   = (waddr == A_CYCLES);
  assign sel_tctrl = (waddr == A_TCTRL);
  assign sel_tcmp  = (waddr == A_TCMP);
  assign sel_tstat = (waddr == A_TSTAT);
  assign sel_tcnt  = (waddr == A_TCNT);
  assign sel_led   = (waddr == A_LED);
  assign mapped    = sel_mem | sel_cyc | sel_tctrl | sel_tcmp | sel_tstat | sel_tcnt | sel_led;
  assign wr        = enable & write_enable;
  assign rd        = enable & ~write_enable;
  assign mem_rdata = mem[mem_idx];
  assign unused_bits = ^{Address[1:0], din};

  // Next-state logic for counters, timer, registers and the read path.
  always_comb begin
    cyc_d     = cyc_q + CNT_W'(1);
    tcmp_d    = tcmp_q;
    tcnt_d    = tcnt_q;
    tctrl_d   = tctrl_q;
    flag_d    = flag_q;
    led_d     = led_q;
    dout_d    = dout_q;
    rvalid_d  = rd;
    bus_err_d = enable & ~mapped;

    match = tctrl_q[0] && (tcnt_q == tcmp_q);
    if (tctrl_q[0]) tcnt_d = match ? '0 : tcnt_q + CNT_W'(1);

    // A clear and a new match in the same cycle leave the flag set.
    if (wr && sel_tstat && din[0]) flag_d = 1'b0;
    if (match) flag_d = 1'b1;

    // CPU stores override the timer's own update.
    if (wr) begin
      if (sel_tctrl) tctrl_d = din[1:0];
      if (sel_tcmp)  tcmp_d  = din[CNT_W-1:0];
      if (sel_tcnt)  tcnt_d  = din[CNT_W-1:0];
      if (sel_led)   led_d   = din[LED_W-1:0];
    end

    if (rd) begin
      if (sel_mem)        dout_d = mem_rdata;
      else if (sel_cyc)   dout_d = 32'(cyc_q);
      else if (sel_tctrl) dout_d = 32'(tctrl_q);
      else if (sel_tcmp)  dout_d = 32'(tcmp_q);
      else if (sel_tstat) dout_d = 32'(flag_q);
      else if (sel_tcnt)  dout_d = 32'(tcnt_q);
      else if (sel_led)   dout_d = 32'(led_q);
      else                dout_d = '0;
    end

    irq_d = flag_d & tctrl_d[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q     <= '0;
      tcmp_q    <= '1;
      tcnt_q    <= '0;
      tctrl_q   <= '0;
      flag_q    <= 1'b0;
      led_q     <= '0;
      dout_q    <= '0;
      rvalid_q  <= 1'b0;
      bus_err_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      cyc_q     <= cyc_d;
      tcmp_q    <= tcmp_d;
      tcnt_q    <= tcnt_d;
      tctrl_q   <= tctrl_d;
      flag_q    <= flag_d;
      led_q     <= led_d;
      dout_q    <= dout_d;
      rvalid_q  <= rvalid_d;
      bus_err_q <= bus_err_d;
      irq_q     <= irq_d;
    end
  end

  // Data memory has no reset value; reset only blocks an in-flight store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
    end else if (wr && sel_mem) begin
      mem[mem_idx] <= din;
    end
  end

  assign dout        = dout_q;
  assign rvalid      = rvalid_q;
  assign bus_err     = bus_err_q;
  assign irq         = irq_q;
  assign leds        = led_q;
  assign cycles_dout = 32'(cyc_q);

endmodule
